clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_chan.sv | 116 +++++++++++
 rtl/clk_div_gen.sv | 37 +++
 tb/tb_clk_div_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel programmable clock divider.
package clk_div_pkg;

  // Default geometry of the divider bank
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 2;

  // Per-channel output mode encoding
  localparam logic MODE_PULSE  = 1'b0;  // one ref cycle high per period
  localparam logic MODE_SQUARE = 1'b1;  // near-50% duty

  // Ratio loaded into both shadow and active registers at reset
  localparam int RST_RATIO = 2;

endpackage : clk_div_pkg

// File: rtl/clk_div_chan.sv
// One divider channel: shadow ratio S, active ratio A, period counter C,
// a pending-update flag, and registered divided-clock / tick outputs.
// A only changes at a period boundary (or while the channel is idle), so a
// reload never truncates or stretches the period already in progress.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] n,
  output logic             out_freq,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_RATIO = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_A     = WIDTH'(RST_RATIO);

  // Number of high cycles in square mode: ceil(a/2), one bit wider so that
  // the all-ones ratio does not wrap.
  function automatic logic [WIDTH:0] ceil_half(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    return t >> 1;
  endfunction

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             busy_q, busy_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             run;
  logic             wrap;
  logic             square_hi;

  // Next-state logic: counter, ratio hand-over, pending flag and outputs.
  always_comb begin
    s_d       = s_q;
    a_d       = a_q;
    c_d       = c_q;
    busy_d    = busy_q;
    out_d     = 1'b0;
    tick_d    = 1'b0;
    run       = 1'b0;
    wrap      = 1'b0;
    square_hi = 1'b0;

    // A ratio below 2 cannot be divided; treat the channel as disabled.
    run  = en && (a_q >= MIN_RATIO);
    // >= rather than == keeps the counter bounded even if A ever shrank
    // underneath it.
    wrap = run && (c_q >= (a_q - ONE));

    if (load) begin
      s_d = n;
    end

    if (!run) begin
      // Idle: counter parked at 0, A follows S without waiting for a boundary.
      c_d = '0;
      a_d = s_q;
    end else if (wrap) begin
      // Period boundary: new ratio takes effect for the next period. A load
      // arriving in this same cycle lands in S and waits one more period.
      c_d = '0;
      a_d = s_q;
    end else begin
      c_d = c_q + ONE;
    end

    // Pending flag compares against the ratio that will be active after this
    // edge, so a load coinciding with a boundary stays pending correctly.
    if (load) begin
      busy_d = (n != a_d);
    end else if (!run || wrap) begin
      busy_d = 1'b0;
    end

    square_hi = ({1'b0, c_q} < ceil_half(a_q));
    if (run) begin
      out_d  = (mode == MODE_SQUARE) ? square_hi : (c_q == '0);
      tick_d = wrap;
    end
  end

  // State and output registers; everything returns to the reset ratio.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= RST_A;
      a_q    <= RST_A;
      c_q    <= '0;
      busy_q <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      a_q    <= a_d;
      c_q    <= c_d;
      busy_q <= busy_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_freq = out_q;
  assign tick     = tick_q;
  assign busy     = busy_q;

endmodule : clk_div_chan

// File: rtl/clk_div_gen.sv
// Bank of independent programmable clock dividers sharing one reference
// clock and one ratio-load strobe.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                      RefClk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] N,
  input  logic [CHANNELS-1:0]       mode,
  input  logic                      load,
  output logic [CHANNELS-1:0]       OutFreq,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       busy
);

  // One channel per ratio slice; load is broadcast to every channel.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clk_div_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .ref_clk  (RefClk),
      .rst_n    (reset),
      .en       (en[i]),
      .mode     (mode[i]),
      .load     (load),
      .n        (N[i*WIDTH +: WIDTH]),
      .out_freq (OutFreq[i]),
      .tick     (tick[i]),
      .busy     (busy[i])
    );
  end

endmodule : clk_div_gen

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen (WIDTH=8, CHANNELS=2).
module tb_clk_div_gen;

  logic        RefClk;
  logic        reset;
  logic [1:0]  en;
  logic [15:0] N;
  logic [1:0]  mode;
  logic        load;
  logic [1:0]  OutFreq;
  logic [1:0]  tick;
  logic [1:0]  busy;

  int n_chk;
  int n_fail;

  logic [1:0] h_out  [0:399];
  logic [1:0] h_tick [0:399];
  logic [1:0] h_busy [0:399];

  clk_div_gen #(
    .WIDTH    (8),
    .CHANNELS (2)
  ) dut (
    .RefClk  (RefClk),
    .reset   (reset),
    .en      (en),
    .N       (N),
    .mode    (mode),
    .load    (load),
    .OutFreq (OutFreq),
    .tick    (tick),
    .busy    (busy)
  );

  initial begin
    RefClk = 1'b0;
    forever #5 RefClk = ~RefClk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample outputs on n falling edges; optionally raise load for the edge
  // that follows sample index load_at.
  task automatic record(input int n, input int load_at, input logic [15:0] load_n);
    for (int i = 0; i < n; i++) begin
      @(negedge RefClk);
      h_out[i]  = OutFreq;
      h_tick[i] = tick;
      h_busy[i] = busy;
      if (i == load_at) begin
        N    = load_n;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
  endtask

  // Stop the channels and load a new ratio bus so A follows it while idle.
  task automatic prep(input logic [15:0] nbus);
    en   = 2'b00;
    N    = nbus;
    load = 1'b1;
    @(negedge RefClk);
    load = 1'b0;
    @(negedge RefClk);
  endtask

  function automatic int run_len(input int ch, input int start, input logic val);
    int k;
    k = start;
    while (k < 400 && h_out[k][ch] === val) k++;
    return k - start;
  endfunction

  function automatic int tick_cnt(input int ch, input int from, input int to);
    int s;
    s = 0;
    for (int k = from; k < to; k++) s += int'(h_tick[k][ch]);
    return s;
  endfunction

  function automatic int out_cnt(input int ch, input int from, input int to);
    int s;
    s = 0;
    for (int k = from; k < to; k++) s += int'(h_out[k][ch]);
    return s;
  endfunction

  function automatic logic [3:0] opat(input int ch);
    return {h_out[0][ch], h_out[1][ch], h_out[2][ch], h_out[3][ch]};
  endfunction

  function automatic logic [3:0] tpat(input int ch);
    return {h_tick[0][ch], h_tick[1][ch], h_tick[2][ch], h_tick[3][ch]};
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    en     = 2'b00;
    N      = 16'h0000;
    mode   = 2'b00;
    load   = 1'b0;

    // Reset held for 5 cycles, release with en=0, then ratio 2 square wave
    repeat (5) @(negedge RefClk);
    chk("rst_out", 32'({OutFreq, tick, busy}), 0);
    reset = 1'b1;
    @(negedge RefClk);
    chk("rel_idle", 32'({OutFreq, tick, busy}), 0);
    en   = 2'b01;
    mode = 2'b11;
    record(4, -1, 16'h0000);
    chk("a2_out_pat", 32'(opat(0)), 32'b1010);
    chk("a2_tick_pat", 32'(tpat(0)), 32'b0101);
    chk("a2_ch1_off", 32'(opat(1)), 0);

    // Even and odd square ratios: 184 on ch0, 7 on ch1
    en   = 2'b00;
    N    = {8'd7, 8'd184};
    load = 1'b1;
    @(negedge RefClk);
    chk("ld_busy_set", 32'(busy), 32'b11);
    load = 1'b0;
    @(negedge RefClk);
    chk("ld_busy_clr_idle", 32'(busy), 0);
    en   = 2'b11;
    mode = 2'b11;
    record(368, -1, 16'h0000);
    chk("n184_high", 32'(run_len(0, 0, 1'b1)), 92);
    chk("n184_low", 32'(run_len(0, 92, 1'b0)), 92);
    chk("n184_ticks", 32'(tick_cnt(0, 0, 368)), 2);
    chk("n184_tick_pos", 32'(h_tick[183][0]), 1);
    chk("n7_high", 32'(run_len(1, 0, 1'b1)), 4);
    chk("n7_low", 32'(run_len(1, 4, 1'b0)), 3);
    chk("n7_ticks", 32'(tick_cnt(1, 0, 368)), 52);
    chk("n7_tick_pos", 32'(h_tick[6][1]), 1);

    // Mid-period reload: running with 10, load 4 while C=3
    prep({8'd7, 8'd10});
    en   = 2'b01;
    mode = 2'b00;
    record(24, 2, {8'd7, 8'd4});
    chk("rl_busy_c3", 32'(h_busy[3]), 32'b01);
    chk("rl_busy_c8", 32'(h_busy[8][0]), 1);
    chk("rl_busy_wrap", 32'(h_busy[9][0]), 0);
    chk("rl_tick_10", 32'(h_tick[9][0]), 1);
    chk("rl_old_period", 32'(out_cnt(0, 1, 10)), 0);
    chk("rl_pulse_10", 32'(h_out[10][0]), 1);
    chk("rl_gap", 32'(out_cnt(0, 11, 14)), 0);
    chk("rl_pulse_14", 32'(h_out[14][0]), 1);
    chk("rl_pulse_18", 32'(h_out[18][0]), 1);
    chk("rl_tick_13", 32'(h_tick[13][0]), 1);

    // Load coinciding with the wrap cycle: old S for one period, then new N
    prep({8'd7, 8'd6});
    en   = 2'b01;
    mode = 2'b00;
    record(20, 4, {8'd7, 8'd3});
    chk("lw_tick_5", 32'(h_tick[5][0]), 1);
    chk("lw_busy_5", 32'(h_busy[5][0]), 1);
    chk("lw_pulse_6", 32'(h_out[6][0]), 1);
    chk("lw_no_early", 32'(out_cnt(0, 7, 12)), 0);
    chk("lw_busy_10", 32'(h_busy[10][0]), 1);
    chk("lw_busy_11", 32'(h_busy[11][0]), 0);
    chk("lw_pulse_12", 32'(h_out[12][0]), 1);
    chk("lw_pulse_15", 32'(h_out[15][0]), 1);
    chk("lw_tick_14", 32'(h_tick[14][0]), 1);

    // Illegal ratio 1 holds outputs low; loading 5 recovers a pulse train
    prep({8'd7, 8'd1});
    en   = 2'b01;
    mode = 2'b00;
    record(12, -1, 16'h0000);
    chk("ill_out", 32'(out_cnt(0, 0, 12)), 0);
    chk("ill_tick", 32'(tick_cnt(0, 0, 12)), 0);
    record(20, 0, {8'd7, 8'd5});
    chk("rec_busy_set", 32'(h_busy[1][0]), 1);
    chk("rec_busy_clr", 32'(h_busy[2][0]), 0);
    chk("rec_pulse_3", 32'(h_out[3][0]), 1);
    chk("rec_pulse_8", 32'(h_out[8][0]), 1);
    chk("rec_pulse_cnt", 32'(out_cnt(0, 3, 18)), 3);
    chk("rec_tick_7", 32'(h_tick[7][0]), 1);

    // Asynchronous reset at C=50 of ratio 184 with a reload pending
    prep({8'd7, 8'd184});
    en   = 2'b11;
    mode = 2'b11;
    record(51, 40, {8'd7, 8'd100});
    chk("pre_rst_out", 32'(h_out[50]), 32'b11);
    chk("pre_rst_busy", 32'(h_busy[50]), 32'b01);
    #2;
    reset = 1'b0;
    #1;
    chk("async_out", 32'(OutFreq), 0);
    chk("async_tick", 32'(tick), 0);
    chk("async_busy", 32'(busy), 0);
    en = 2'b00;
    repeat (2) @(negedge RefClk);
    reset = 1'b1;
    @(negedge RefClk);
    chk("rel2_idle", 32'({OutFreq, tick, busy}), 0);
    en   = 2'b11;
    mode = 2'b11;
    record(4, -1, 16'h0000);
    chk("rst_ratio_ch0", 32'(opat(0)), 32'b1010);
    chk("rst_ratio_ch1", 32'(opat(1)), 32'b1010);
    chk("rst_tick_ch1", 32'(tpat(1)), 32'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_clk_div_gen
